// File: rtl/usb_rx_cmd_decoder.sv
// ASCII command decoder driving four board LEDs from the FT2232H RX byte stream.
// Latency: single-byte commands act on the accept edge; 'S'<hex><CR|LF> applies one edge after the terminator.
// Backpressure: rx_ready drops only for the single EXEC cycle (and while in reset); no path from rx_valid.
module usb_rx_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4,
    output logic       cmd_err,
    output logic [7:0] cmd_count,
    output logic [7:0] err_count
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MASK, TERM, EXEC} state_t;

    state_t          state, state_nxt;
    logic            alive_r;
    logic [3:0]      leds_r, leds_nxt;
    logic [3:0]      mask_r, mask_nxt;
    logic [TO_W-1:0] to_cnt, to_nxt;
    logic            err_evt;
    logic            cmd_inc;
    logic            accept;
    logic            timeout;
    logic            is_term;
    logic [1:0]      led_idx;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] b);
        return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
    endfunction

    assign accept  = rx_valid && rx_ready;
    assign is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign led_idx = rx_data[1:0] - 2'd1;
    // An accept on the limit edge wins over the timeout.
    assign timeout = ((state == MASK) || (state == TERM)) && !accept && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && (rx_data == 8'h53 || rx_data == 8'h73)) state_nxt = MASK;
            MASK: begin
                if (accept)       state_nxt = is_hex(rx_data) ? TERM : IDLE;
                else if (timeout) state_nxt = IDLE;
            end
            TERM: begin
                if (accept)       state_nxt = is_term ? EXEC : IDLE;
                else if (timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = alive_r && (state != EXEC);
        leds_nxt = leds_r;
        mask_nxt = mask_r;
        to_nxt   = '0;
        err_evt  = 1'b0;
        cmd_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (rx_data)
                        8'h31, 8'h32, 8'h33, 8'h34: begin
                            leds_nxt[led_idx] = ~leds_r[led_idx];
                            cmd_inc           = 1'b1;
                        end
                        8'h43, 8'h63: begin
                            leds_nxt = 4'b0000;
                            cmd_inc  = 1'b1;
                        end
                        8'h53, 8'h73, 8'h0D, 8'h0A, 8'h20: ;
                        default: err_evt = 1'b1;
                    endcase
                end
            end
            MASK: begin
                if (accept) begin
                    if (is_hex(rx_data)) mask_nxt = hex_val(rx_data);
                    else                 err_evt  = 1'b1;
                end else if (timeout) begin
                    err_evt = 1'b1;
                end else begin
                    to_nxt = to_cnt + TO_W'(1);
                end
            end
            TERM: begin
                if (accept) begin
                    err_evt = !is_term;
                end else if (timeout) begin
                    err_evt = 1'b1;
                end else begin
                    to_nxt = to_cnt + TO_W'(1);
                end
            end
            default: begin
                leds_nxt = mask_r;
                cmd_inc  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive_r   <= 1'b0;
            leds_r    <= 4'b0000;
            mask_r    <= 4'b0000;
            to_cnt    <= '0;
            cmd_err   <= 1'b0;
            cmd_count <= 8'd0;
            err_count <= 8'd0;
        end else begin
            alive_r   <= 1'b1;
            leds_r    <= leds_nxt;
            mask_r    <= mask_nxt;
            to_cnt    <= to_nxt;
            cmd_err   <= err_evt;
            cmd_count <= cmd_count + {7'd0, cmd_inc};
            if (err_evt && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end

    assign {led4, led3, led2, led1} = leds_r;

endmodule

// File: tb/tb_usb_rx_cmd_decoder.sv
// Randomized bench for usb_rx_cmd_decoder against a command-level reference model.
module tb_usb_rx_cmd_decoder;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       led1, led2, led3, led4;
    logic       cmd_err;
    logic [7:0] cmd_count;
    logic [7:0] err_count;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    usb_rx_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .led1(led1), .led2(led2), .led3(led3), .led4(led4),
        .cmd_err(cmd_err), .cmd_count(cmd_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the partially received command as a byte count.
    int       m_alive, m_exec, m_exec_mask, m_pend_len, m_pend_nib, m_idle, m_cmd, m_errc;
    bit       m_err;
    bit [3:0] m_leds;

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        bit acc;
        bit e;
        int hv;
        int k;
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_alive = 0; m_exec = 0; m_exec_mask = 0; m_pend_len = 0; m_pend_nib = 0;
            m_idle = 0; m_cmd = 0; m_errc = 0; m_err = 1'b0; m_leds = 4'b0000;
        end else begin
            e   = 1'b0;
            acc = rx_valid && (m_alive != 0) && (m_exec == 0);
            if (m_exec != 0) begin
                m_leds = 4'(m_exec_mask);
                m_cmd  = (m_cmd + 1) % 256;
                m_exec = 0;
            end else if (acc) begin
                m_idle = 0;
                if (m_pend_len == 0) begin
                    if (rx_data >= 8'h31 && rx_data <= 8'h34) begin
                        k = int'(rx_data) - 49;
                        m_leds[k] = ~m_leds[k];
                        m_cmd = (m_cmd + 1) % 256;
                    end else if (rx_data == "C" || rx_data == "c") begin
                        m_leds = 4'b0000;
                        m_cmd  = (m_cmd + 1) % 256;
                    end else if (rx_data == "S" || rx_data == "s") begin
                        m_pend_len = 1;
                    end else if (!(rx_data == 8'h0D || rx_data == 8'h0A || rx_data == 8'h20)) begin
                        e = 1'b1;
                    end
                end else if (m_pend_len == 1) begin
                    hv = hexval(rx_data);
                    if (hv >= 0) begin
                        m_pend_nib = hv;
                        m_pend_len = 2;
                    end else begin
                        e = 1'b1;
                        m_pend_len = 0;
                    end
                end else begin
                    if (rx_data == 8'h0D || rx_data == 8'h0A) begin
                        m_exec = 1;
                        m_exec_mask = m_pend_nib;
                    end else begin
                        e = 1'b1;
                    end
                    m_pend_len = 0;
                end
            end else if (m_pend_len > 0) begin
                m_idle++;
                if (m_idle == TMO) begin
                    e = 1'b1;
                    m_pend_len = 0;
                    m_idle = 0;
                end
            end
            m_alive = 1;
            m_err   = e;
            if (e && m_errc < 255) m_errc++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("rx_ready", int'(rx_ready), int'(reset && m_alive != 0 && m_exec == 0));
            check("leds", int'({led4, led3, led2, led1}), int'(m_leds));
            check("cmd_err", int'(cmd_err), int'(m_err));
            check("cmd_count", int'(cmd_count), m_cmd);
            check("err_count", int'(err_count), m_errc);
        end
    end

    task automatic to_neg();
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) to_neg();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int n = 0; n < 20; n++) begin
            if (rx_ready) begin
                to_neg();
                rx_valid = 1'b0;
                return;
            end
            to_neg();
        end
        rx_valid = 1'b0;
        check("send_handshake_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        to_neg();
        reset = 1'b1;
    endtask

    logic [7:0] tbl [0:19] = '{8'h31, 8'h32, 8'h33, 8'h34, "C", "c", "S", "s", 8'h0D, 8'h0A,
                               8'h20, "0", "9", "A", "F", "a", "f", "G", "#", 8'h35};
    string hx = "0123456789ABCDEFabcdef";

    initial begin
        int r;
        logic [7:0] b;
        reset = 1'b0;
        rx_valid = 1'b0;
        repeat (2) to_neg();
        cmp_en = 1'b1;
        check("reset_rx_ready", int'(rx_ready), 0);
        check("reset_leds", int'({led4, led3, led2, led1}), 0);
        check("reset_cmd_count", int'(cmd_count), 0);
        reset = 1'b1;
        to_neg();
        check("release_rx_ready", int'(rx_ready), 1);

        send(8'h31);
        check("t2_led1_on", int'(led1), 1);
        check("t2_cmd1", int'(cmd_count), 1);
        send(8'h31);
        check("t2_led1_off", int'(led1), 0);
        check("t2_cmd2", int'(cmd_count), 2);
        send(8'h34);
        check("t2_led4_on", int'(led4), 1);

        send("S"); send("A"); send(8'h0D);
        check("t3_exec_not_ready", int'(rx_ready), 0);
        check("t3_leds_before", int'({led4, led3, led2, led1}), 4'b1000);
        to_neg();
        check("t3_leds_after", int'({led4, led3, led2, led1}), 4'b1010);
        check("t3_ready_back", int'(rx_ready), 1);
        check("t3_cmd4", int'(cmd_count), 4);

        send(8'h35);
        check("t4_err_pulse", int'(cmd_err), 1);
        check("t4_err1", int'(err_count), 1);
        check("t4_leds_kept", int'({led4, led3, led2, led1}), 4'b1010);
        send("S"); send("G");
        check("t4_err2", int'(err_count), 2);

        send("S");
        idle(15);
        check("t5_no_early_timeout", int'(cmd_err), 0);
        idle(1);
        check("t5_timeout_pulse", int'(cmd_err), 1);
        check("t5_err3", int'(err_count), 3);
        send("F");
        check("t5_err4", int'(err_count), 4);

        send("S");
        idle(15);
        send("3");
        check("limit_accept_wins", int'(err_count), 4);
        send(8'h0A);
        to_neg();
        check("limit_leds", int'({led4, led3, led2, led1}), 4'b0011);
        check("limit_cmd5", int'(cmd_count), 5);

        send("S"); send("5");
        reset = 1'b0;
        #1;
        check("t6_async_leds", int'({led4, led3, led2, led1}), 0);
        check("t6_ready_low", int'(rx_ready), 0);
        to_neg();
        reset = 1'b1;
        to_neg();
        send(8'h0D);
        check("t6_no_err", int'(cmd_err), 0);
        check("t6_cmd0", int'(cmd_count), 0);
        to_neg();
        check("t6_leds0", int'({led4, led3, led2, led1}), 0);

        for (int i = 0; i < 260; i++) send("#");
        check("err_saturate", int'(err_count), 255);
        pulse_reset();
        to_neg();
        for (int i = 0; i < 257; i++) send(8'h31);
        check("cmd_wrap", int'(cmd_count), 1);
        check("wrap_led1", int'(led1), 1);

        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                pulse_reset();
            end else if (r < 30) begin
                send(r[0] ? "S" : "s");
                b = hx[int'($urandom_range(0, 21))];
                if ($urandom_range(0, 9) == 0) b = 8'($urandom);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(14, 17)));
                send(b);
                b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
                if ($urandom_range(0, 9) == 0) b = 8'($urandom);
                if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(14, 17)));
                send(b);
            end else if (r < 85) begin
                send(tbl[$urandom_range(0, 19)]);
            end else begin
                send(8'($urandom));
            end
            idle(int'($urandom_range(0, 2)));
        end
        idle(3);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
